// File: rtl/clk_rst_seq.sv
// clk_rst_seq: reset sequencer and clock-enable generator for the 18 MHz PLL domain.
//
// Holds downstream logic in reset until the PLL lock flag has been stable for
// HOLD_CYCLES clocks, then releases sys_rst_o and emits divided clock-enable
// strobes. Losing lock while running drops straight back into reset.
//
// Optional feature macro: CLK_RST_SEQ_STATUS_EN
//   defined   : sticky lock_lost_o flag (cleared by lock_lost_clr_i) and a
//               saturating run-time lock-loss counter lock_drop_cnt_o.
//   undefined : lock_lost_o / lock_drop_cnt_o tied to 0, lock_lost_clr_i ignored.
//
// Ports:
//   clk_i           PLL output clock
//   rst_i           asynchronous active-high reset
//   pll_locked_i    PLL lock flag, asynchronous to clk_i
//   lock_lost_clr_i synchronous clear of lock_lost_o
//   sys_rst_o       active-high system reset, synchronous deassert
//   pix_ce_o        single-cycle pixel enable (every PIX_DIV cycles in RUN)
//   cpu_ce_o        single-cycle CPU enable (every CPU_DIV cycles in RUN)
//   lock_lost_o     sticky flag: lock lost while running
//   lock_drop_cnt_o saturating count of run-time lock losses
module clk_rst_seq #(
  parameter int unsigned HOLD_CYCLES = 1024,  // 1..65535
  parameter int unsigned PIX_DIV     = 3,     // 2..15
  parameter int unsigned CPU_DIV     = 12     // multiple of PIX_DIV, up to 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       lock_lost_clr_i,
  output logic       sys_rst_o,
  output logic       pix_ce_o,
  output logic       cpu_ce_o,
  output logic       lock_lost_o,
  output logic [7:0] lock_drop_cnt_o
);

  typedef enum logic [1:0] {StWaitLock, StHold, StRun} state_e;

  localparam logic [15:0] HoldLoad = 16'(HOLD_CYCLES - 1);
  localparam logic [3:0]  PixLast  = 4'(PIX_DIV - 1);
  localparam logic [7:0]  CpuLast  = 8'(CPU_DIV - 1);

  logic [1:0]  sync_q;
  logic        lock_s;
  state_e      state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  pix_cnt_q, pix_cnt_d;
  logic [7:0]  cpu_cnt_q, cpu_cnt_d;
  logic        sys_rst_q, sys_rst_d;
  logic        pix_ce_q, pix_ce_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic        run_d;
  logic        lost_set;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lost_set   = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end
      end
      StHold: begin
        if (!lock_s) begin
          // A drop before release is not a run-time loss.
          state_d    = StWaitLock;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == 16'd0) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d  = StWaitLock;
          lost_set = 1'b1;
        end
      end
      default: state_d = StWaitLock;
    endcase

    // Outputs are registered from next-state so they change on the same edge
    // as the FSM transition.
    run_d     = (state_d == StRun);
    pix_cnt_d = '0;
    cpu_cnt_d = '0;
    if (run_d && (state_q == StRun)) begin
      pix_cnt_d = (pix_cnt_q == PixLast) ? 4'd0 : pix_cnt_q + 4'd1;
      cpu_cnt_d = (cpu_cnt_q == CpuLast) ? 8'd0 : cpu_cnt_q + 8'd1;
    end
    sys_rst_d = !run_d;
    pix_ce_d  = run_d && (pix_cnt_d == PixLast);
    cpu_ce_d  = run_d && (cpu_cnt_d == CpuLast);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      state_q    <= StWaitLock;
      hold_cnt_q <= '0;
      pix_cnt_q  <= '0;
      cpu_cnt_q  <= '0;
      sys_rst_q  <= 1'b1;
      pix_ce_q   <= 1'b0;
      cpu_ce_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], pll_locked_i};
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      cpu_cnt_q  <= cpu_cnt_d;
      sys_rst_q  <= sys_rst_d;
      pix_ce_q   <= pix_ce_d;
      cpu_ce_q   <= cpu_ce_d;
    end
  end

  assign sys_rst_o = sys_rst_q;
  assign pix_ce_o  = pix_ce_q;
  assign cpu_ce_o  = cpu_ce_q;

`ifdef CLK_RST_SEQ_STATUS_EN
  logic       lock_lost_q, lock_lost_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    lock_lost_d = lock_lost_q;
    drop_cnt_d  = drop_cnt_q;
    // Set has priority over a simultaneous clear.
    if (lost_set) begin
      lock_lost_d = 1'b1;
    end else if (lock_lost_clr_i) begin
      lock_lost_d = 1'b0;
    end
    if (lost_set && (drop_cnt_q != 8'hff)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_lost_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      lock_lost_q <= lock_lost_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign lock_lost_o     = lock_lost_q;
  assign lock_drop_cnt_o = drop_cnt_q;
`else
  logic unused_status;
  assign unused_status   = lost_set ^ lock_lost_clr_i;
  assign lock_lost_o     = 1'b0;
  assign lock_drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: self-checking bench for clk_rst_seq (HOLD_CYCLES=16, PIX_DIV=3,
// CPU_DIV=12). Works with or without CLK_RST_SEQ_STATUS_EN defined.
module tb_clk_rst_seq;

  localparam int unsigned HoldCycles = 16;
  localparam int unsigned PixDiv     = 3;
  localparam int unsigned CpuDiv     = 12;
  localparam int          RelEdges   = HoldCycles + 3;

`ifdef CLK_RST_SEQ_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       lock_lost_clr;
  logic       sys_rst;
  logic       pix_ce;
  logic       cpu_ce;
  logic       lock_lost;
  logic [7:0] lock_drop_cnt;

  int checks = 0;
  int errors = 0;
  int drops  = 0;  // run-time lock losses since last reset
  int pix_q[$];
  int cpu_q[$];

  clk_rst_seq #(
    .HOLD_CYCLES(HoldCycles),
    .PIX_DIV    (PixDiv),
    .CPU_DIV    (CpuDiv)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pll_locked_i   (pll_locked),
    .lock_lost_clr_i(lock_lost_clr),
    .sys_rst_o      (sys_rst),
    .pix_ce_o       (pix_ce),
    .cpu_ce_o       (cpu_ce),
    .lock_lost_o    (lock_lost),
    .lock_drop_cnt_o(lock_drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_cnt(input int n);
    if (!StatusEn) return 8'd0;
    if (n > 255) return 8'd255;
    return 8'(n);
  endfunction

  function automatic logic exp_lost(input logic v);
    return StatusEn ? v : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until sys_rst is seen low; bounded so a stuck DUT returns 200.
  task automatic wait_release(output int edges);
    edges = 0;
    while (edges < 200 && sys_rst !== 1'b0) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    int e;
    rst = 1'b1; pll_locked = 1'b1; lock_lost_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sys_rst !== 1'b1) begin
        errors++; $display("FAIL reset_sys_rst cyc %0d: got %b expected 1", i, sys_rst);
      end
    end
    checks++;
    if ({pix_ce, cpu_ce, lock_lost} !== 3'b000 || lock_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pix=%b cpu=%b lost=%b cnt=%0d expected all 0",
               pix_ce, cpu_ce, lock_lost, lock_drop_cnt);
    end
    rst = 1'b0;
    drops = 0;
    wait_release(e);
    checks++;
    if (e != RelEdges) begin
      errors++; $display("FAIL reset_release_edges: got %0d expected %0d", e, RelEdges);
    end
  endtask

  // Entered in RUN cycle 0.
  task automatic test_cadence();
    int pix_n = 0;
    int cpu_n = 0;
    int e;
    for (int c = 0; c < 120; c++) begin
      if (c % PixDiv == PixDiv - 1) pix_q.push_back(c);
      if (c % CpuDiv == CpuDiv - 1) cpu_q.push_back(c);
    end
    for (int c = 0; c < 120; c++) begin
      if (pix_ce === 1'b1) begin
        pix_n++;
        checks++;
        if (pix_q.size() == 0) begin
          errors++; $display("FAIL cadence_pix_extra: got pulse at %0d expected none", c);
        end else begin
          e = pix_q.pop_front();
          if (e != c) begin
            errors++; $display("FAIL cadence_pix_cycle: got %0d expected %0d", c, e);
          end
        end
      end
      if (cpu_ce === 1'b1) begin
        cpu_n++;
        checks++;
        if (cpu_q.size() == 0) begin
          errors++; $display("FAIL cadence_cpu_extra: got pulse at %0d expected none", c);
        end else begin
          e = cpu_q.pop_front();
          if (e != c) begin
            errors++; $display("FAIL cadence_cpu_cycle: got %0d expected %0d", c, e);
          end
        end
        checks++;
        if (pix_ce !== 1'b1) begin
          errors++; $display("FAIL cadence_coincide cyc %0d: got pix=%b expected 1", c, pix_ce);
        end
      end
      tick();
    end
    checks++;
    if (pix_n != 40 || cpu_n != 10) begin
      errors++; $display("FAIL cadence_counts: got pix=%0d cpu=%0d expected 40/10", pix_n, cpu_n);
    end
    checks++;
    if (pix_q.size() != 0 || cpu_q.size() != 0) begin
      errors++;
      $display("FAIL cadence_missing: got %0d/%0d unmatched expected 0/0",
               pix_q.size(), cpu_q.size());
    end
    pix_q.delete();
    cpu_q.delete();
  endtask

  task automatic test_hold_glitch();
    int e;
    bit stayed = 1'b1;
    rst = 1'b1; pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    drops = 0;
    tick();
    pll_locked = 1'b1;
    repeat (10) begin
      tick();
      if (sys_rst !== 1'b1) stayed = 1'b0;
    end
    pll_locked = 1'b0;
    tick();
    if (sys_rst !== 1'b1) stayed = 1'b0;
    checks++;
    if (!stayed) begin
      errors++; $display("FAIL glitch_sys_rst_held: got release expected sys_rst=1");
    end
    pll_locked = 1'b1;
    wait_release(e);
    checks++;
    if (e != RelEdges) begin
      errors++; $display("FAIL glitch_release_edges: got %0d expected %0d", e, RelEdges);
    end
    checks++;
    if (lock_drop_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_drop_cnt: got %0d expected 0", lock_drop_cnt);
    end
  endtask

  task automatic test_runtime_loss();
    int e;
    repeat (5) tick();
    pll_locked = 1'b0;
    tick(); tick();
    checks++;
    if (sys_rst !== 1'b0) begin
      errors++; $display("FAIL loss_early: got sys_rst=%b expected 0 after 2 edges", sys_rst);
    end
    tick();
    drops++;
    checks++;
    if (sys_rst !== 1'b1 || pix_ce !== 1'b0 || cpu_ce !== 1'b0) begin
      errors++;
      $display("FAIL loss_outputs: got rst=%b pix=%b cpu=%b expected 1/0/0", sys_rst, pix_ce, cpu_ce);
    end
    checks++;
    if (lock_lost !== exp_lost(1'b1) || lock_drop_cnt !== exp_cnt(drops)) begin
      errors++;
      $display("FAIL loss_status1: got lost=%b cnt=%0d expected %b/%0d",
               lock_lost, lock_drop_cnt, exp_lost(1'b1), exp_cnt(drops));
    end
    pll_locked = 1'b1;
    wait_release(e);
    checks++;
    if (e != RelEdges) begin
      errors++; $display("FAIL loss_relock_edges: got %0d expected %0d", e, RelEdges);
    end
    repeat (4) tick();
    pll_locked = 1'b0;
    tick(); tick();
    lock_lost_clr = 1'b1;  // coincides with the set edge
    tick();
    lock_lost_clr = 1'b0;
    drops++;
    checks++;
    if (lock_lost !== exp_lost(1'b1) || lock_drop_cnt !== exp_cnt(drops)) begin
      errors++;
      $display("FAIL loss_set_wins: got lost=%b cnt=%0d expected %b/%0d",
               lock_lost, lock_drop_cnt, exp_lost(1'b1), exp_cnt(drops));
    end
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    checks++;
    if (lock_lost !== 1'b0 || lock_drop_cnt !== exp_cnt(drops)) begin
      errors++;
      $display("FAIL loss_clear: got lost=%b cnt=%0d expected 0/%0d",
               lock_lost, lock_drop_cnt, exp_cnt(drops));
    end
  endtask

  task automatic test_saturation();
    int e;
    int bad = 0;
    while (drops < 260) begin
      pll_locked = 1'b1;
      wait_release(e);
      if (e != RelEdges) bad++;
      pll_locked = 1'b0;
      repeat (3) tick();
      drops++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sat_release: got %0d bad releases expected 0", bad);
    end
    checks++;
    if (lock_drop_cnt !== exp_cnt(drops) || sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL sat_count: got cnt=%0d rst=%b expected %0d/1",
               lock_drop_cnt, sys_rst, exp_cnt(drops));
    end
  endtask

  task automatic test_async_reset();
    int e;
    int n = 0;
    pll_locked = 1'b1;
    wait_release(e);
    while (n < 10 && pix_ce !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (pix_ce !== 1'b1 || sys_rst !== 1'b0) begin
      errors++; $display("FAIL async_pre: got pix=%b rst=%b expected 1/0", pix_ce, sys_rst);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sys_rst !== 1'b1 || pix_ce !== 1'b0 || cpu_ce !== 1'b0) begin
      errors++;
      $display("FAIL async_outputs: got rst=%b pix=%b cpu=%b expected 1/0/0", sys_rst, pix_ce, cpu_ce);
    end
    checks++;
    if (lock_lost !== 1'b0 || lock_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_status: got lost=%b cnt=%0d expected 0/0", lock_lost, lock_drop_cnt);
    end
    drops = 0;
    tick();
    rst = 1'b0;
    wait_release(e);
    checks++;
    if (e != RelEdges) begin
      errors++; $display("FAIL async_release_edges: got %0d expected %0d", e, RelEdges);
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_hold_glitch();
    test_runtime_loss();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
